// File: rtl/adder_entry_ctrl.sv
// adder_entry_ctrl: debounced one-button entry of A, B and carry-in for a 2-bit adder; drives operands, latches sum, selects HEX digit codes (ports: clock/reset, sw_val, key_n, sum_in in; op_a/op_b/op_cin, digit0/digit1, state_led, done out)
module adder_entry_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] sw_val,
  input  logic       key_n,
  input  logic [2:0] sum_in,
  output logic [1:0] op_a,
  output logic [1:0] op_b,
  output logic       op_cin,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] state_led,
  output logic       done
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  typedef enum logic [2:0] {S_A, S_B, S_CIN, S_CALC, S_SHOW} state_e;
  state_e state_q, state_d;
  logic [1:0] sync_q;
  logic deb_q, deb_prev_q, press;
  logic [CW-1:0] cnt_q;
  logic [1:0] op_a_q, op_b_q;
  logic op_cin_q, done_q;
  logic [2:0] result_q;
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q     <= 2'b11;
      deb_q      <= 1'b1;
      deb_prev_q <= 1'b1;
      cnt_q      <= '0;
    end else begin
      sync_q     <= {sync_q[0], key_n};
      deb_prev_q <= deb_q;
      if (sync_q[1] == deb_q) cnt_q <= '0;
      else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        deb_q <= sync_q[1];
        cnt_q <= '0;
      end else cnt_q <= cnt_q + CW'(1);
    end
  end
  assign press = deb_prev_q & ~deb_q;
  always_ff @(posedge clock) begin
    if (reset) state_q <= S_A;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_A:     state_d = press ? S_B : S_A;
      S_B:     state_d = press ? S_CIN : S_B;
      S_CIN:   state_d = press ? S_CALC : S_CIN;
      S_CALC:  state_d = S_SHOW;
      S_SHOW:  state_d = press ? S_A : S_SHOW;
      default: state_d = S_A;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      op_a_q   <= '0;
      op_b_q   <= '0;
      op_cin_q <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= state_q == S_CALC;
      if (state_q == S_CALC) result_q <= sum_in;
      if (press && state_q == S_A) op_a_q <= sw_val;
      if (press && state_q == S_B) op_b_q <= sw_val;
      if (press && state_q == S_CIN) op_cin_q <= sw_val[0];
      if (press && state_q == S_SHOW) begin
        op_a_q   <= '0;
        op_b_q   <= '0;
        op_cin_q <= 1'b0;
      end
    end
  end
  always_comb begin
    digit0    = 4'hF;
    digit1    = 4'hF;
    state_led = 4'b0000;
    case (state_q)
      S_A: begin
        digit0    = {2'b00, sw_val};
        digit1    = 4'd1;
        state_led = 4'b0001;
      end
      S_B: begin
        digit0    = {2'b00, sw_val};
        digit1    = 4'd2;
        state_led = 4'b0010;
      end
      S_CIN: begin
        digit0    = {3'b000, sw_val[0]};
        digit1    = 4'd3;
        state_led = 4'b0100;
      end
      S_SHOW: begin
        digit0    = {1'b0, result_q};
        state_led = 4'b1000;
      end
      default: ;
    endcase
  end
  assign op_a   = op_a_q;
  assign op_b   = op_b_q;
  assign op_cin = op_cin_q;
  assign done   = done_q;
endmodule

// File: tb/tb_adder_entry_ctrl.sv
// tb_adder_entry_ctrl: scenario tasks with a result scoreboard for adder_entry_ctrl at DEBOUNCE_CYCLES = 4
module tb_adder_entry_ctrl;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [1:0] sw_val = 2'd2;
  logic key_n = 1'b1;
  logic [2:0] sum_in;
  logic [1:0] op_a, op_b;
  logic op_cin, done;
  logic [3:0] digit0, digit1, state_led;
  int errors = 0;
  int checks = 0;
  logic [2:0] exp_q[$];
  logic [2:0] a_m, b_m;
  logic c_m;
  adder_entry_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .clock(clock), .reset(reset), .sw_val(sw_val), .key_n(key_n), .sum_in(sum_in),
    .op_a(op_a), .op_b(op_b), .op_cin(op_cin), .digit0(digit0), .digit1(digit1),
    .state_led(state_led), .done(done)
  );
  always #5 clock = ~clock;
  assign sum_in = 3'(op_a) + 3'(op_b) + 3'(op_cin);
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic press_hold(input logic [1:0] sw);
    sw_val = sw;
    key_n = 1'b0;
    repeat (7) step();
  endtask
  task automatic release_key();
    key_n = 1'b1;
    repeat (8) step();
  endtask
  task automatic enter(input logic [1:0] a, input logic [1:0] b, input logic c);
    a_m = 3'(a);
    b_m = 3'(b);
    c_m = c;
    press_hold(a);
    release_key();
    press_hold(b);
    release_key();
    exp_q.push_back(a_m + b_m + 3'(c_m));
    press_hold({1'b0, c});
  endtask
  task automatic wait_done(input string name);
    logic [2:0] e;
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      if (done) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s done_timeout got no done within 10 cycles", name);
    end else if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard_empty got done with nothing expected", name);
    end else begin
      e = exp_q.pop_front();
      if (digit0 !== {1'b0, e} || state_led !== 4'b1000) begin
        errors++;
        $display("FAIL %s result got digit0=%0h led=%b exp digit0=%0h led=1000", name, digit0, state_led, e);
      end
    end
  endtask
  task automatic test_reset();
    repeat (3) step();
    reset = 1'b0;
    checks++;
    if ({op_a, op_b, op_cin} !== 5'd0 || state_led !== 4'b0001 || digit1 !== 4'd1 || digit0 !== 4'd2 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset got a=%0d b=%0d c=%0d led=%b d1=%0h d0=%0h done=%b exp 0 0 0 0001 1 2 0", op_a, op_b, op_cin, state_led, digit1, digit0, done);
    end
  endtask
  task automatic test_clean();
    press_hold(2'd3);
    checks++;
    if (op_a !== 2'd3 || state_led !== 4'b0010) begin
      errors++;
      $display("FAIL clean_a got a=%0d led=%b exp a=3 led=0010", op_a, state_led);
    end
    release_key();
    press_hold(2'd3);
    checks++;
    if (op_b !== 2'd3 || state_led !== 4'b0100 || digit1 !== 4'd3) begin
      errors++;
      $display("FAIL clean_b got b=%0d led=%b d1=%0h exp b=3 led=0100 d1=3", op_b, state_led, digit1);
    end
    release_key();
    exp_q.push_back(3'd7);
    press_hold(2'd1);
    checks++;
    if (op_cin !== 1'b1 || state_led !== 4'b0000 || digit0 !== 4'hF || digit1 !== 4'hF || done !== 1'b0) begin
      errors++;
      $display("FAIL clean_calc got c=%b led=%b d0=%0h d1=%0h done=%b exp 1 0000 f f 0", op_cin, state_led, digit0, digit1, done);
    end
    step();
    checks++;
    if (done !== 1'b1 || digit1 !== 4'hF || dut.result_q !== 3'd7) begin
      errors++;
      $display("FAIL clean_done got done=%b d1=%0h result=%0d exp 1 f 7", done, digit1, dut.result_q);
    end
    if (done && exp_q.size() > 0) begin
      checks++;
      if (digit0 !== {1'b0, exp_q.pop_front()} || state_led !== 4'b1000) begin
        errors++;
        $display("FAIL clean_show got d0=%0h led=%b exp d0=7 led=1000", digit0, state_led);
      end
    end
    step();
    checks++;
    if (done !== 1'b0 || digit0 !== 4'd7) begin
      errors++;
      $display("FAIL clean_pulse got done=%b d0=%0h exp done=0 d0=7", done, digit0);
    end
    release_key();
    press_hold(2'd0);
    checks++;
    if ({op_a, op_b, op_cin} !== 5'd0 || state_led !== 4'b0001) begin
      errors++;
      $display("FAIL clean_back got a=%0d b=%0d c=%b led=%b exp 0 0 0 0001", op_a, op_b, op_cin, state_led);
    end
    release_key();
  endtask
  task automatic test_bounce();
    int moved;
    moved = 0;
    sw_val = 2'd2;
    for (int i = 0; i < 20; i++) begin
      key_n = (i % 4) < 2 ? 1'b0 : 1'b1;
      step();
      if (state_led !== 4'b0001) moved++;
    end
    checks++;
    if (moved != 0) begin
      errors++;
      $display("FAIL bounce_quiet got %0d cycles off S_A exp 0", moved);
    end
    key_n = 1'b0;
    repeat (6) step();
    checks++;
    if (state_led !== 4'b0001) begin
      errors++;
      $display("FAIL bounce_early got led=%b exp 0001", state_led);
    end
    step();
    checks++;
    if (state_led !== 4'b0010 || op_a !== 2'd2) begin
      errors++;
      $display("FAIL bounce_advance got led=%b a=%0d exp 0010 a=2", state_led, op_a);
    end
    release_key();
  endtask
  task automatic test_hold();
    int changes;
    logic [3:0] prev;
    changes = 0;
    prev = state_led;
    sw_val = 2'd1;
    key_n = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (state_led !== prev) changes++;
      prev = state_led;
      if (i == 10) sw_val = 2'd3;
    end
    checks++;
    if (changes != 1 || state_led !== 4'b0100 || op_b !== 2'd1) begin
      errors++;
      $display("FAIL hold got changes=%0d led=%b b=%0d exp 1 0100 1", changes, state_led, op_b);
    end
    key_n = 1'b1;
    sw_val = 2'd0;
    repeat (10) step();
    checks++;
    if (op_b !== 2'd1 || state_led !== 4'b0100) begin
      errors++;
      $display("FAIL hold_keep got b=%0d led=%b exp 1 0100", op_b, state_led);
    end
  endtask
  task automatic test_reset_mid();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (op_a !== 2'd0 || op_b !== 2'd0 || state_led !== 4'b0001 || dut.result_q !== 3'd0) begin
      errors++;
      $display("FAIL reset_mid got a=%0d b=%0d led=%b result=%0d exp 0 0 0001 0", op_a, op_b, state_led, dut.result_q);
    end
    repeat (8) step();
  endtask
  task automatic test_full();
    enter(2'd0, 2'd0, 1'b0);
    wait_done("full_000");
    release_key();
    press_hold(2'd3);
    checks++;
    if ({op_a, op_b, op_cin} !== 5'd0 || state_led !== 4'b0001) begin
      errors++;
      $display("FAIL full_return got a=%0d b=%0d c=%b led=%b exp 0 0 0 0001", op_a, op_b, op_cin, state_led);
    end
    release_key();
    enter(2'd2, 2'd1, 1'b1);
    wait_done("full_211");
    release_key();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left got %0d entries exp 0", exp_q.size());
    end
  endtask
  initial begin
    test_reset();
    test_clean();
    test_bounce();
    test_hold();
    test_reset_mid();
    test_full();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/adder_entry_ctrl.md
# adder_entry_ctrl

Sequencing controller for the board-level two-bit adder datapath. It collects operand A, operand B and carry-in one at a time from the slide switches using a single debounced push-button. It drives the registered operands into the adder, captures the adder's 3-bit sum, and selects the 4-bit digit codes fed to the two seven-segment decoders (HEX0, HEX1).

## Interface
Parameters:
- DEBOUNCE_CYCLES, 500000 — consecutive stable cycles required before the synchronized button level is accepted (10 ms at 50 MHz); minimum 2.

Ports:
- clock  in  1  — system clock, all state on rising edge
- reset  in  1  — synchronous, active-high
- sw_val  in  2  — operand switches (asynchronous, quasi-static)
- key_n  in  1  — raw push-button, active-low, bouncy, asynchronous
- sum_in  in  3  — combinational a+b+cin from the adder (0..7)
- op_a  out  2  — operand A to adder, registered
- op_b  out  2  — operand B to adder, registered
- op_cin  out  1  — carry-in to adder, registered
- digit0  out  4  — code for HEX0 decoder (0..9 digit, 4'hF blank)
- digit1  out  4  — code for HEX1 decoder
- state_led  out  4  — one-hot phase indicator
- done  out  1  — one-cycle pulse when a result is captured

## Operation
- Button conditioning: key_n passes through a two-flop synchronizer (reset value 1). Debounced level `deb` resets to 1. Counter resets to 0 and clears whenever sync output equals `deb`; otherwise it increments. When count reaches DEBOUNCE_CYCLES-1 while still differing, `deb` takes the sync value at the next edge and the counter clears. Press event `press` = `deb` transitioned 1->0 (registered previous-`deb` compare), high exactly one cycle per accepted press. Release produces no event.
- FSM states: S_A, S_B, S_CIN, S_CALC, S_SHOW; reset -> S_A.
  - S_A: on press, op_a <= sw_val, go to S_B.
  - S_B: on press, op_b <= sw_val, go to S_CIN.
  - S_CIN: on press, op_cin <= sw_val[0], go to S_CALC.
  - S_CALC (exactly one cycle, press ignored): result_q <= sum_in, done <= 1, go to S_SHOW.
  - S_SHOW: on press, op_a/op_b/op_cin <= 0, go to S_A.
- Operands hold their values in all other cycles.
- Display (combinational from state, result_q, sw_val):
  - S_A: digit0 = {2'b0, sw_val}, digit1 = 1.
  - S_B: digit0 = {2'b0, sw_val}, digit1 = 2.
  - S_CIN: digit0 = {3'b0, sw_val[0]}, digit1 = 3.
  - S_CALC: digit0 = 4'hF, digit1 = 4'hF.
  - S_SHOW: digit0 = {1'b0, result_q}, digit1 = 4'hF.
- state_led: bit0 S_A, bit1 S_B, bit2 S_CIN, bit3 S_SHOW; all-zero in S_CALC.
- Arithmetic: sum_in is 3 bits and never overflows (max 3+3+1 = 7). result_q is 3 bits, reset 0.

## Timing
- Reset values: op_a = 0, op_b = 0, op_cin = 0, result_q = 0, done = 0, state S_A (state_led = 4'b0001, digit1 = 1).
- key_n low from edge t with no bounce: sync low after edge t+2, `deb` low after edge t+2+DEBOUNCE_CYCLES, press high for the following cycle. The FSM acts on the edge ending that cycle.
- Press accepted at edge N in S_CIN:
  - op_cin valid and state S_CALC after N.
  - sum_in sampled at edge N+1.
  - result_q, done = 1 and S_SHOW after N+1.
  - done low after N+2.
- Any bounce shorter than DEBOUNCE_CYCLES resets the counter; no event is generated.
- Key held indefinitely yields exactly one press.
- Reset asserted in any state, including S_CALC, overrides press: all registers return to reset values at that edge, including synchronizer, counter and `deb`. A key held through reset produces one press after deassert plus 2+DEBOUNCE_CYCLES cycles.
- sw_val changes after a press do not affect captured operands.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4.
- Reset for 3 cycles, sw_val = 2 -> op_a = op_b = op_cin = 0, state_led = 0001, digit1 = 1, digit0 = 2, done = 0.
- Clean presses with sw_val 3, then 3, then 1, sum model driven -> op_a = 3, op_b = 3, op_cin = 1. One cycle after S_CALC: digit0 = 7, digit1 = F, state_led = 1000, done high exactly one cycle.
- key_n toggles every 2 cycles for 20 cycles, then held low -> no state change during toggling; exactly one advance S_A -> S_B, 2+4 cycles after the hold begins (+1 for press).
- key_n held low for 100 cycles in S_B -> exactly one transition to S_CIN; op_b captured once; sw_val changes afterward do not alter op_b.
- Reset pulsed in S_CIN with op_a = 2, op_b = 1 -> next cycle op_a = op_b = 0, state_led = 0001, result_q = 0.
- Full 0+0+0 sequence, then press in S_SHOW -> digit0 = 0 in S_SHOW; after the press, state S_A and operands 0. A second full sequence 2+1+1 shows 4.
